// File: rtl/ex_mem_result_buf_pkg.sv
// alu_pipe_pkg: ALU function codes, skid-buffer state and EX/MEM entry
// layout shared by the EX/MEM result buffer and its users.
package alu_pipe_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALUFN_W    = 6;

    localparam logic [ALUFN_W-1:0] ALU_ADD = 6'b000000;
    localparam logic [ALUFN_W-1:0] ALU_SUB = 6'b000001;
    localparam logic [ALUFN_W-1:0] ALU_MUL = 6'b000010;
    localparam logic [ALUFN_W-1:0] ALU_AND = 6'b000100;
    localparam logic [ALUFN_W-1:0] ALU_OR  = 6'b000101;
    localparam logic [ALUFN_W-1:0] ALU_XOR = 6'b000110;
    localparam logic [ALUFN_W-1:0] ALU_SLL = 6'b001000;
    localparam logic [ALUFN_W-1:0] ALU_SRL = 6'b001001;
    localparam logic [ALUFN_W-1:0] ALU_SLT = 6'b001011;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    typedef struct packed {
        logic [DATA_W-1:0]     result;
        logic                  zero;
        logic [ALUFN_W-1:0]    alufn;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic [DATA_W-1:0]     store_data;
        logic                  exc;
    } entry_t;

    // Only signed add/sub overflow raises a trap.
    function automatic logic is_trap_fn(
        input logic [ALUFN_W-1:0] fn
    );
        return (fn == ALU_ADD) || (fn == ALU_SUB);
    endfunction

endpackage

// File: rtl/ex_mem_result_buf_if.sv
// EX/MEM handshake bundle: execute-side offer and memory-side head entry.
// master = surrounding pipeline, slave = the result buffer.
interface ex_mem_result_buf_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALUFN_W    = 6
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_result;
    logic                  in_zero;
    logic                  in_overflow;
    logic [ALUFN_W-1:0]    in_alufn;
    logic [REG_ADDR_W-1:0] in_rd;
    logic                  in_reg_write;
    logic                  in_mem_read;
    logic                  in_mem_write;
    logic [DATA_W-1:0]     in_store_data;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     out_result;
    logic                  out_zero;
    logic [ALUFN_W-1:0]    out_alufn;
    logic [REG_ADDR_W-1:0] out_rd;
    logic                  out_reg_write;
    logic                  out_mem_read;
    logic                  out_mem_write;
    logic [DATA_W-1:0]     out_store_data;
    logic                  out_exc;

    modport master (
        output in_valid, in_result, in_zero, in_overflow,
        output in_alufn, in_rd, in_reg_write,
        output in_mem_read, in_mem_write, in_store_data,
        input  in_ready,
        input  out_valid, out_result, out_zero, out_alufn,
        input  out_rd, out_reg_write, out_mem_read,
        input  out_mem_write, out_store_data, out_exc,
        output out_ready
    );

    modport slave (
        input  in_valid, in_result, in_zero, in_overflow,
        input  in_alufn, in_rd, in_reg_write,
        input  in_mem_read, in_mem_write, in_store_data,
        output in_ready,
        output out_valid, out_result, out_zero, out_alufn,
        output out_rd, out_reg_write, out_mem_read,
        output out_mem_write, out_store_data, out_exc,
        input  out_ready
    );
endinterface

// File: rtl/ex_mem_result_buf_skid.sv
// pipe_skid_buf: generic 2-entry skid buffer. in_ready comes only from
// registered state so no combinational path runs back from out_ready.
module pipe_skid_buf
    import alu_pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o,
    output logic [1:0]   occupancy_o
);

    buf_state_t   state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         rdy_en_q;
    logic         acc, dlv;

    // rdy_en_q keeps in_ready low while in reset and until the first edge.
    assign in_ready_o  = rdy_en_q & (state_q != FULL);
    assign out_valid_o = (state_q != EMPTY);
    assign out_data_o  = main_q;
    assign occupancy_o = state_q;

    assign acc = in_valid_i & in_ready_o;
    assign dlv = out_valid_o & out_ready_i;

    // State and entry registers; reset empties and clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            main_q   <= '0;
            skid_q   <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
            rdy_en_q <= 1'b1;
        end
    end

    // Next state: flush wins, otherwise main always holds the head.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (acc) begin
                        main_d  = in_data_i;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (acc && dlv) begin
                        main_d = in_data_i;
                    end else if (acc) begin
                        skid_d  = in_data_i;
                        state_d = FULL;
                    end else if (dlv) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (dlv) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/ex_mem_result_buf.sv
// ex_mem_result_buf: EX/MEM stage holding ALU result plus sideband.
// Optional overflow trap on ADD/SUB enabled by macro OVERFLOW_TRAP_EN.
module ex_mem_result_buf
    import alu_pipe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALUFN_W    = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    ex_mem_result_buf_if.slave bus,
    output logic [1:0]        occupancy
);

    typedef struct packed {
        logic [DATA_W-1:0]     result;
        logic                  zero;
        logic [ALUFN_W-1:0]    alufn;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic [DATA_W-1:0]     store_data;
        logic                  exc;
    } ent_t;

    ent_t in_ent;
    ent_t out_ent;

    // Pack the offered entry; a trapping op loses its writeback.
    always_comb begin
        in_ent            = '0;
        in_ent.result     = bus.in_result;
        in_ent.zero       = bus.in_zero;
        in_ent.alufn      = bus.in_alufn;
        in_ent.rd         = bus.in_rd;
        in_ent.mem_read   = bus.in_mem_read;
        in_ent.mem_write  = bus.in_mem_write;
        in_ent.store_data = bus.in_store_data;
`ifdef OVERFLOW_TRAP_EN
        in_ent.exc        = bus.in_overflow
                          & is_trap_fn(bus.in_alufn);
        in_ent.reg_write  = bus.in_reg_write & ~in_ent.exc;
`else
        in_ent.exc        = 1'b0;
        in_ent.reg_write  = bus.in_reg_write;
`endif
    end

    pipe_skid_buf #(
        .W ($bits(ent_t))
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid_i  (bus.in_valid),
        .in_ready_o  (bus.in_ready),
        .in_data_i   (in_ent),
        .out_valid_o (bus.out_valid),
        .out_ready_i (bus.out_ready),
        .out_data_o  (out_ent),
        .occupancy_o (occupancy)
    );

    assign bus.out_result     = out_ent.result;
    assign bus.out_zero       = out_ent.zero;
    assign bus.out_alufn      = out_ent.alufn;
    assign bus.out_rd         = out_ent.rd;
    assign bus.out_reg_write  = out_ent.reg_write;
    assign bus.out_mem_read   = out_ent.mem_read;
    assign bus.out_mem_write  = out_ent.mem_write;
    assign bus.out_store_data = out_ent.store_data;

`ifdef OVERFLOW_TRAP_EN
    assign bus.out_exc = out_ent.exc;
`else
    // Without the trap, overflow is ignored and exc is a constant 0.
    logic unused_trap;
    assign unused_trap = bus.in_overflow ^ out_ent.exc;
    assign bus.out_exc = 1'b0;
`endif

endmodule

// File: tb/tb_ex_mem_result_buf.sv
// Bench for ex_mem_result_buf: directed plus random traffic checked
// against a FIFO-queue reference model of the 2-entry buffer.
module tb_ex_mem_result_buf;
    import alu_pipe_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic [1:0] occupancy;

    ex_mem_result_buf_if bus ();

    ex_mem_result_buf dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    int     n_cmp = 0;
    int     n_bad = 0;
    entry_t q[$];
    bit     alive = 1'b0;

    logic [ALUFN_W-1:0] fns [9] = '{
        ALU_ADD, ALU_SUB, ALU_MUL, ALU_AND, ALU_OR,
        ALU_XOR, ALU_SLL, ALU_SRL, ALU_SLT
    };

    task automatic chk(string tag, logic [95:0] obs,
                       logic [95:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    function automatic entry_t expect_of(entry_t e, logic ovf);
        entry_t r;
        r = e;
        r.exc = 1'b0;
`ifdef OVERFLOW_TRAP_EN
        if (ovf && (e.alufn == ALU_ADD || e.alufn == ALU_SUB)) begin
            r.reg_write = 1'b0;
            r.exc = 1'b1;
        end
`else
        if (ovf) r.exc = 1'b0;
`endif
        return r;
    endfunction

    function automatic entry_t rnd_entry();
        entry_t e;
        e.result     = $urandom;
        e.zero       = 1'($urandom);
        e.alufn      = fns[$urandom_range(0, 8)];
        e.rd         = 5'($urandom);
        e.reg_write  = 1'($urandom);
        e.mem_read   = 1'($urandom);
        e.mem_write  = 1'($urandom);
        e.store_data = $urandom;
        e.exc        = 1'b0;
        return e;
    endfunction

    function automatic entry_t observed();
        entry_t o;
        o.result     = bus.out_result;
        o.zero       = bus.out_zero;
        o.alufn      = bus.out_alufn;
        o.rd         = bus.out_rd;
        o.reg_write  = bus.out_reg_write;
        o.mem_read   = bus.out_mem_read;
        o.mem_write  = bus.out_mem_write;
        o.store_data = bus.out_store_data;
        o.exc        = bus.out_exc;
        return o;
    endfunction

    // One clock: drive, check at negedge, advance model at posedge.
    task automatic step(logic v, entry_t e, logic ovf,
                        logic ordy, logic fl);
        logic exp_rdy, acc, dlv;
        bus.in_valid      = v;
        bus.in_result     = e.result;
        bus.in_zero       = e.zero;
        bus.in_overflow   = ovf;
        bus.in_alufn      = e.alufn;
        bus.in_rd         = e.rd;
        bus.in_reg_write  = e.reg_write;
        bus.in_mem_read   = e.mem_read;
        bus.in_mem_write  = e.mem_write;
        bus.in_store_data = e.store_data;
        bus.out_ready     = ordy;
        flush             = fl;
        @(negedge clk);
        exp_rdy = alive && (q.size() < 2);
        chk("in_ready", 96'(bus.in_ready), 96'(exp_rdy));
        chk("out_valid", 96'(bus.out_valid), 96'(q.size() != 0));
        chk("occupancy", 96'(occupancy), 96'(q.size()));
        if (q.size() != 0)
            chk("head", 96'(observed()), 96'(q[0]));
        acc = v && exp_rdy;
        dlv = (q.size() != 0) && ordy;
        if (fl) begin
            q.delete();
        end else begin
            if (dlv) void'(q.pop_front());
            if (acc) q.push_back(expect_of(e, ovf));
        end
        @(posedge clk);
        #1;
        alive = rst_n;
    endtask

    initial begin
        entry_t z, a, b, c, d;
        z = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_overflow = 1'b0;
        #2;
        chk("rst_valid", 96'(bus.out_valid), 96'(0));
        chk("rst_ready", 96'(bus.in_ready), 96'(0));
        chk("rst_occ", 96'(occupancy), 96'(0));
        chk("rst_result", 96'(bus.out_result), 96'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        alive = 1'b0;
        step(0, z, 0, 1, 0);

        // single ADD
        a = z;
        a.alufn = ALU_ADD;
        a.result = 32'h5;
        a.rd = 5'd3;
        a.reg_write = 1'b1;
        step(1, a, 0, 1, 0);
        step(0, z, 0, 1, 0);
        step(0, z, 0, 1, 0);

        // backpressure A, B, C
        a = rnd_entry();
        b = rnd_entry();
        c = rnd_entry();
        step(1, a, 0, 0, 0);
        step(1, b, 0, 0, 0);
        step(1, c, 0, 0, 0);
        step(1, c, 0, 0, 0);
        step(1, c, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, z, 0, 1, 0);

        // streaming
        for (int i = 0; i < 8; i++) step(1, rnd_entry(), 0, 1, 0);
        step(0, z, 0, 1, 0);
        step(0, z, 0, 1, 0);

        // flush when full with an offer
        step(1, rnd_entry(), 0, 0, 0);
        step(1, rnd_entry(), 0, 0, 0);
        d = rnd_entry();
        step(1, d, 0, 0, 1);
        step(0, z, 0, 1, 0);

        // overflow trap cases
        a = z;
        a.alufn = ALU_ADD;
        a.result = 32'h8000_0000;
        a.rd = 5'd7;
        a.reg_write = 1'b1;
        b = a;
        b.alufn = ALU_MUL;
        c = a;
        c.alufn = ALU_SUB;
        step(1, a, 1, 1, 0);
        step(1, b, 1, 1, 0);
        step(1, c, 1, 1, 0);
        step(0, z, 0, 1, 0);
        step(0, z, 0, 1, 0);

        // asynchronous reset while full
        step(1, rnd_entry(), 0, 0, 0);
        step(1, rnd_entry(), 0, 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 96'(bus.out_valid), 96'(0));
        chk("arst_ready", 96'(bus.in_ready), 96'(0));
        chk("arst_occ", 96'(occupancy), 96'(0));
        chk("arst_result", 96'(bus.out_result), 96'(0));
        q.delete();
        alive = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1, rnd_entry(), 0, 1, 0);
        step(1, rnd_entry(), 0, 1, 0);
        step(0, z, 0, 1, 0);
        step(0, z, 0, 1, 0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), rnd_entry(),
                 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 31) == 0));
        end
        for (int i = 0; i < 3; i++) step(0, z, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
